sopc_data32_wr_arb: RTL and testbench
=====================================

Name: sopc_data32_wr_arb

Overview:
- Round-robin arbiter and write sequencer that shares one 32-bit Avalon-MM output PIO (zero-wait-state, data register at address 0) between NREQ on-chip requesters.
- Each granted request becomes one single-cycle Avalon write to address 0.
- Optionally, a read-back of address 0 follows to confirm the value.
- A programmable idle gap follows so that each value stays visible on the PIO out_port for a guaranteed minimum time.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 32, data width; must match the PIO
- GAP, 2, idle cycles after each transaction before the next grant (0..255)
- VERIFY, 1, 1 = read back address 0 after each write and flag a mismatch; 0 = skip read-back

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- req  in  NREQ  per-requester write request; level, held until ack
- wdata  in  NREQ*DW  requester i data in bits [i*DW +: DW]
- ack  out  NREQ  one-hot, one-cycle pulse; the requester's write is committed
- err  out  1  one-cycle pulse; read-back mismatch
- busy  out  1  high when state is not IDLE
- grant_id  out  3  index of the current or last granted requester
- avm_address  out  2  PIO address; always 0
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active-low
- avm_writedata  out  DW  PIO write data
- avm_readdata  in  DW  PIO read data; combinational, valid in the same cycle as the access

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - ack=0, err=0, busy=0, grant_id=0.
  - avm_chipselect=0, avm_write_n=1, avm_writedata=0, avm_address=0.
  - RR pointer last=NREQ-1, so requester 0 wins first.
- Reset mid-transaction: the transaction is abandoned with no ack and no err. The PIO keeps whatever it already captured.
- FSM states: IDLE, WRITE, VERIFY, GAP.
- IDLE:
  - If req≠0, pick the first set bit searching last+1, last+2, … modulo NREQ.
  - Latch grant_id and wdata[grant] into the data register, set last=grant, go to WRITE.
  - If req=0, stay in IDLE.
- WRITE (exactly 1 cycle):
  - avm_chipselect=1, avm_write_n=0, avm_writedata=latched data.
  - The PIO captures the data at the closing edge.
  - At that edge, ack[grant] is registered high, so it is visible during the next cycle.
  - Next state: VERIFY if VERIFY=1; else GAP if GAP>0; else IDLE.
- VERIFY (exactly 1 cycle):
  - avm_chipselect=1, avm_write_n=1.
  - Compare avm_readdata with the latched data; on mismatch, register err=1 for the next cycle.
  - Next state: GAP if GAP>0, else IDLE.
- GAP:
  - Counter loaded with GAP-1 on entry; decrements each cycle.
  - Go to IDLE when the counter reaches 0, so the FSM spends exactly GAP cycles in GAP.
- Outside WRITE and VERIFY: avm_chipselect=0, avm_write_n=1, avm_writedata holds its last value.
- Latency: req rising in IDLE at cycle 0 gives WRITE in cycle 1 and ack in cycle 2.
- Transaction period: 2+VERIFY+GAP cycles. Minimum is 2 (VERIFY=0, GAP=0) for back-to-back grants.
- Request semantics:
  - A request is committed at grant. Dropping req after grant does not cancel it; ack still pulses.
  - req still high in the cycle after ack is treated as a new request with the current wdata. The requester must update its data or drop req on ack.
  - Requester wdata is sampled only in the IDLE grant cycle.
- Simultaneous requests: strict rotation. Requesters held continuously are served in order last+1 … with no starvation; worst-case wait is (NREQ-1) transactions.
- grant_id holds its value after a transaction until the next grant.

Decomposition:
- Package sopc_arb_pkg holds:
  - state encoding (IDLE=0, WRITE=1, VERIFY=2, GAP=3);
  - PIO_DATA_ADDR=2'd0;
  - GNT_W=3.
- Sub-module sopc_rr_pick: combinational round-robin picker.
  - Inputs: req and last. Outputs: grant index and any.
  - Reused by other shared-PIO controllers.

Test Plan:
- Single request, VERIFY=1, GAP=2: req[1] with wdata1=0xDEADBEEF at cycle 0. Required response:
  - WRITE in cycle 1 with cs=1, write_n=0, writedata=0xDEADBEEF;
  - ack=4'b0010 in cycle 2;
  - VERIFY in cycle 2;
  - busy deasserts in cycle 5; err stays 0.
- Round-robin: req=4'b1111 held, data i=0x1000+i. Required response:
  - writes in order 0,1,2,3,0 at a 5-cycle period;
  - exactly one ack per transaction.
- Read-back mismatch: stub forces avm_readdata=0 for a write of 0x0000_00A5. Required response: err=1 for exactly one cycle, in the first GAP cycle.
- GAP=0, VERIFY=0: req[2] held with data changing each ack. Required response: a write every 2 cycles, each carrying the data present in its grant cycle.
- Request withdrawal and reset: req[3] pulsed for 1 cycle. Required response: still written and acked. Then assert reset_n=0 during WRITE; required response:
  - all outputs reach reset values at the next edge;
  - no ack;
  - after release, requester 0 wins against req=4'b1001.

Source files
------------

// File: rtl/sopc_arb_pkg.sv
// Shared types and constants for the shared-PIO write arbiters.
package sopc_arb_pkg;

  localparam int unsigned GNT_W         = 3;
  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic chipselect;
    logic write_n;
  } avm_ctl_t;

endpackage

// File: rtl/sopc_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module sopc_rr_pick
  import sopc_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GNT_W-1:0] last_i,
  output logic [GNT_W-1:0] grant_o,
  output logic             any_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  int idx;

  // Walk from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    grant_o = '0;
    idx     = 0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      idx = (int'(last_i) + k) % int'(NREQ);
      if (req_i[IDX_W'(idx)]) grant_o = GNT_W'(idx);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sopc_data32_wr_arb.sv
// Round-robin write sequencer sharing one Avalon-MM output PIO between requesters,
// with optional read-back check and a guaranteed idle gap after every write.
module sopc_data32_wr_arb
  import sopc_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned GAP    = 2,
  parameter int unsigned VERIFY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy,
  output logic [GNT_W-1:0]   grant_id,
  output logic [1:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [DW-1:0]      avm_writedata,
  input  logic [DW-1:0]      avm_readdata
);

  localparam int unsigned CNT_W      = 8;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam bit          HAS_VERIFY = (VERIFY != 0);
  localparam bit          HAS_GAP    = (GAP != 0);

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  avm_ctl_t         ctl_q, ctl_d;

  logic [GNT_W-1:0] pick_grant;
  logic             pick_any;
  logic [DW-1:0]    wdata_arr [NREQ];
  logic [DW-1:0]    pick_data;

  sopc_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_wslice
    assign wdata_arr[gi] = wdata[gi*DW +: DW];
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_grant == GNT_W'(i)) pick_data = wdata_arr[i];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          last_d  = pick_grant;
          data_d  = pick_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        for (int i = 0; i < int'(NREQ); i++) ack_d[i] = (grant_q == GNT_W'(i));
        cnt_d   = GAP_LOAD;
        state_d = HAS_VERIFY ? ST_VERIFY : (HAS_GAP ? ST_GAP : ST_IDLE);
      end
      ST_VERIFY: begin
        err_d   = (avm_readdata != data_q);
        cnt_d   = GAP_LOAD;
        state_d = HAS_GAP ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    ctl_d.chipselect = (state_d == ST_WRITE) || (state_d == ST_VERIFY);
    ctl_d.write_n    = (state_d != ST_WRITE);
    busy_d           = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_W'(NREQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ctl_q   <= '{chipselect: 1'b0, write_n: 1'b1};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ctl_q   <= ctl_d;
    end
  end

  assign ack            = ack_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign avm_address    = PIO_DATA_ADDR;
  assign avm_chipselect = ctl_q.chipselect;
  assign avm_write_n    = ctl_q.write_n;
  assign avm_writedata  = data_q;

endmodule

// File: tb/tb_sopc_data32_wr_arb.sv
// Bench for sopc_data32_wr_arb: directed plus random traffic against a per-transaction schedule model.
module tb_sopc_data32_wr_arb;

  localparam int NREQ = 4;
  localparam int NCYC = 1200;
  localparam int PER  = 5;   // 2 + VERIFY(1) + GAP(2)
  localparam int AW   = NCYC + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic         rst_a = 1'b0;
  logic [3:0]   req_a = '0;
  logic [127:0] wdata_a = '0;
  logic [3:0]   ack_a;
  logic         err_a, busy_a, cs_a, wn_a;
  logic [2:0]   gid_a;
  logic [1:0]   addr_a;
  logic [31:0]  wd_a, rd_a;
  logic [31:0]  pio_q = '0;
  logic         rd_force = 1'b0;
  logic [31:0]  rd_force_val = '0;

  // DUT B: GAP=0, VERIFY=0
  logic         rst_b = 1'b0;
  logic [3:0]   req_b = '0;
  logic [127:0] wdata_b = '0;
  logic [3:0]   ack_b;
  logic         err_b, busy_b, cs_b, wn_b;
  logic [2:0]   gid_b;
  logic [1:0]   addr_b;
  logic [31:0]  wd_b;

  sopc_data32_wr_arb dut_a (
    .clk(clk), .reset_n(rst_a), .req(req_a), .wdata(wdata_a), .ack(ack_a), .err(err_a),
    .busy(busy_a), .grant_id(gid_a), .avm_address(addr_a), .avm_chipselect(cs_a),
    .avm_write_n(wn_a), .avm_writedata(wd_a), .avm_readdata(rd_a));

  sopc_data32_wr_arb #(.GAP(0), .VERIFY(0)) dut_b (
    .clk(clk), .reset_n(rst_b), .req(req_b), .wdata(wdata_b), .ack(ack_b), .err(err_b),
    .busy(busy_b), .grant_id(gid_b), .avm_address(addr_b), .avm_chipselect(cs_b),
    .avm_write_n(wn_b), .avm_writedata(wd_b), .avm_readdata(32'd0));

  // PIO stub: data register captured on write, optionally corrupted on read
  always @(posedge clk) if (cs_a && !wn_a) pio_q <= wd_a;
  assign rd_a = rd_force ? rd_force_val : pio_q;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Expected per-cycle outputs, filled in from the transaction schedule
  bit        exp_wr [AW];
  bit        exp_vf [AW];
  bit        exp_er [AW];
  bit        exp_bs [AW];
  bit [3:0]  exp_ack[AW];
  bit        wd_set [AW];
  bit [31:0] wd_val [AW];
  bit [31:0] vf_data[AW];
  bit        gid_set[AW];
  bit [2:0]  gid_val[AW];
  bit [31:0] cur_wd;
  bit [2:0]  cur_gid;
  int        last_m = NREQ - 1;
  int        t_free = 0;

  task automatic check_a(input int c);
    if (wd_set[c])  cur_wd  = wd_val[c];
    if (gid_set[c]) cur_gid = gid_val[c];
    chk("chipselect", 64'(cs_a), 64'(exp_wr[c] | exp_vf[c]));
    chk("write_n",    64'(wn_a), 64'(!exp_wr[c]));
    chk("ack",        64'(ack_a), 64'(exp_ack[c]));
    chk("err",        64'(err_a), 64'(exp_er[c]));
    chk("busy",       64'(busy_a), 64'(exp_bs[c]));
    chk("writedata",  64'(wd_a), 64'(cur_wd));
    chk("grant_id",   64'(gid_a), 64'(cur_gid));
    chk("address",    64'(addr_a), 64'd0);
  endtask

  task automatic model_a(input int c);
    int g;
    int i;
    bit [31:0] d;
    if (exp_vf[c]) exp_er[c+1] = (rd_a != vf_data[c]);
    if (!rst_a) begin
      for (int k = c + 1; k < AW; k++) begin
        exp_wr[k] = 0; exp_vf[k] = 0; exp_er[k] = 0; exp_bs[k] = 0;
        exp_ack[k] = '0; wd_set[k] = 0; gid_set[k] = 0;
      end
      t_free = c + 1;
      last_m = NREQ - 1;
      wd_set[c+1] = 1;  wd_val[c+1] = '0;
      gid_set[c+1] = 1; gid_val[c+1] = '0;
    end else if (c >= t_free && req_a != 4'd0) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        i = (last_m + k) % NREQ;
        if (g < 0 && req_a[i]) g = i;
      end
      last_m = g;
      d = wdata_a[g*32 +: 32];
      exp_wr[c+1]  = 1;
      wd_set[c+1]  = 1; wd_val[c+1]  = d;
      gid_set[c+1] = 1; gid_val[c+1] = 3'(g);
      exp_ack[c+2] = 4'(1 << g);
      exp_vf[c+2]  = 1; vf_data[c+2] = d;
      for (int k = 1; k < PER; k++) exp_bs[c+k] = 1;
      t_free = c + PER;
    end
  endtask

  task automatic drive_a(input int c);
    rst_a = 1'b1;
    rd_force = 1'b0;
    rd_force_val = $urandom;
    if (c < 2) begin
      rst_a = 1'b0; req_a = '0;
    end else if (c < 12) begin
      req_a = (c < 4) ? 4'b0010 : 4'b0000;
      wdata_a = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    end else if (c == 12) begin
      rst_a = 1'b0; req_a = '0;
    end else if (c < 45) begin
      req_a = (c < 41) ? 4'b1111 : 4'b0000;
      wdata_a = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    end else if (c < 55) begin
      req_a = (c < 47) ? 4'b0001 : 4'b0000;
      wdata_a = {96'h0, 32'h0000_00A5};
      rd_force = 1'b1; rd_force_val = '0;
    end else if (c < 70) begin
      wdata_a = {$urandom, $urandom, $urandom, $urandom};
      if (c < 60)       req_a = (c == 55) ? 4'b1000 : 4'b0000;
      else if (c == 60) req_a = 4'b0001;
      else begin
        req_a = 4'b1001;
        if (c == 61) rst_a = 1'b0;
      end
    end else begin
      rst_a = ($urandom_range(0, 199) != 0);
      req_a = req_a ^ (4'($urandom) & 4'($urandom));
      wdata_a = {$urandom, $urandom, $urandom, $urandom};
      rd_force = ($urandom_range(0, 5) == 0);
    end
  endtask

  bit [31:0] db[20];

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      drive_a(c);
      @(negedge clk);
      cyc = c;
      if (c > 0) check_a(c);
      model_a(c);
    end

    // Back-to-back writes with no read-back and no gap
    @(posedge clk); #1; rst_b = 1'b0;
    @(posedge clk); #1; rst_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wdata_b = {$urandom, $urandom, $urandom, $urandom};
      db[k] = wdata_b[95:64];
      req_b = 4'b0100;
      @(negedge clk);
      cyc = NCYC + k;
      if (k % 2 == 1) begin
        chk("b_chipselect", 64'(cs_b), 64'd1);
        chk("b_write_n",    64'(wn_b), 64'd0);
        chk("b_writedata",  64'(wd_b), 64'(db[k-1]));
        chk("b_ack",        64'(ack_b), 64'd0);
        chk("b_grant_id",   64'(gid_b), 64'd2);
      end else begin
        chk("b_chipselect", 64'(cs_b), 64'd0);
        chk("b_ack",        64'(ack_b), (k == 0) ? 64'd0 : 64'b0100);
      end
      chk("b_busy", 64'(busy_b), 64'(k % 2 == 1));
      chk("b_err",  64'(err_b), 64'd0);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
